uart_cmd_assembler: RTL and testbench

//  - Downstream stage of the UART byte receiver: consumes its rx_data/rdy byte stream.
//  - Assembles 5-byte command frames: SYNC(0xA5), CMD, DATA_HI, DATA_LO, CSUM.
//  - Validates each frame by checksum and presents {cmd, data} with a sticky cmd_rdy flag
//    to the segway control/auth logic.
//  - Counts framing/checksum errors for debug.

---
 rtl/uart_cmd_assembler_pkg.sv | 22 ++
 rtl/uart_cmd_assembler_if.sv | 20 ++
 rtl/uart_cmd_assembler_timer.sv | 30 +++
 rtl/uart_cmd_assembler.sv | 142 ++++++++++++++
 tb/tb_uart_cmd_assembler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_assembler_pkg.sv
// rtl/uart_cmd_assembler_pkg.sv - shared types and constants for the UART command frame assembler
package uart_cmd_pkg;

   localparam int         FRAME_LEN         = 5;
   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [$clog2(FRAME_LEN)-1:0] {
      HUNT,
      CMD,
      DHI,
      DLO,
      CSUM
   } asm_state_t;

   // Frame checksum: plain 8-bit wrapping sum of the three payload bytes.
   function automatic logic [7:0] frame_csum(input logic [7:0] c,
                                             input logic [7:0] hi,
                                             input logic [7:0] lo);
      return c + hi + lo;
   endfunction

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// rtl/uart_cmd_assembler_if.sv - receiver byte stream and command output bundles
interface uart_byte_if;
   logic [7:0] rx_data;
   logic       rx_rdy;
   logic       clr_rx_rdy;

   modport master (output rx_data, output rx_rdy, input  clr_rx_rdy);
   modport slave  (input  rx_data, input  rx_rdy, output clr_rx_rdy);
endinterface

interface cmd_out_if;
   logic [7:0]  cmd;
   logic [15:0] data;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic [7:0]  err_cnt;

   modport master (output cmd, output data, output cmd_rdy, output err_cnt, input  clr_cmd_rdy);
   modport slave  (input  cmd, input  data, input  cmd_rdy, input  err_cnt, output clr_cmd_rdy);
endinterface

// File: rtl/uart_cmd_assembler_timer.sv
// rtl/uart_cmd_assembler_timer.sv - cmd_byte_timer: inter-byte gap counter with one-cycle expire pulse
module cmd_byte_timer #(
   parameter int TIMEOUT_CYC = 104160,
   parameter int TO_W        = 17
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic clr,
   output logic expire
);

   localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT_CYC - 1);

   logic [TO_W-1:0] cnt;

   // A byte arriving on the last count wins: clr masks the expire pulse.
   assign expire = run && !clr && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || !run || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles SYNC/CMD/HI/LO/CSUM frames into {cmd,data}; CMD_TIMEOUT_EN adds inter-byte timeout
module uart_cmd_assembler
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT,
   parameter int         TIMEOUT_CYC = 104160,
   parameter int         TO_W        = 17
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_byte_if.slave rx,
   cmd_out_if.master  host
);

   asm_state_t  state_q, state_d;
   logic [7:0]  cmd_s, hi_s, lo_s;
   logic [7:0]  cmd_q;
   logic [15:0] data_q;
   logic        cmd_rdy_q;
   logic [7:0]  err_q;

   logic        byte_acc;
   logic        load_cmd, load_hi, load_lo;
   logic        frame_good, frame_bad, to_err;
   logic        to_expire;

   if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > (1 << TO_W)) begin : g_bad_timeout_cfg
      $error("uart_cmd_assembler: TIMEOUT_CYC does not fit in TO_W bits");
   end

   assign byte_acc      = rx.rx_rdy;
   assign rx.clr_rx_rdy = rx.rx_rdy;

`ifdef CMD_TIMEOUT_EN
   cmd_byte_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .run    (state_q != HUNT),
      .clr    (byte_acc),
      .expire (to_expire)
   );
`else
   assign to_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      load_cmd   = 1'b0;
      load_hi    = 1'b0;
      load_lo    = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      to_err     = 1'b0;
      case (state_q)
         HUNT: begin
            if (byte_acc && rx.rx_data == SYNC_BYTE) state_d = CMD;
         end
         CMD: begin
            if (byte_acc) begin
               load_cmd = 1'b1;
               state_d  = DHI;
            end
         end
         DHI: begin
            if (byte_acc) begin
               load_hi = 1'b1;
               state_d = DLO;
            end
         end
         DLO: begin
            if (byte_acc) begin
               load_lo = 1'b1;
               state_d = CSUM;
            end
         end
         CSUM: begin
            if (byte_acc) begin
               state_d = HUNT;
               if (rx.rx_data == frame_csum(cmd_s, hi_s, lo_s)) frame_good = 1'b1;
               else                                             frame_bad  = 1'b1;
            end
         end
         default: state_d = HUNT;
      endcase
      if (to_expire) begin
         state_d = HUNT;
         to_err  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_s <= '0;
         hi_s  <= '0;
         lo_s  <= '0;
      end else begin
         if (load_cmd) cmd_s <= rx.rx_data;
         if (load_hi)  hi_s  <= rx.rx_data;
         if (load_lo)  lo_s  <= rx.rx_data;
      end
   end

   // Set beats clear so a frame completing alongside an ack is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_q     <= '0;
         data_q    <= '0;
         cmd_rdy_q <= 1'b0;
      end else if (frame_good) begin
         cmd_q     <= cmd_s;
         data_q    <= {hi_s, lo_s};
         cmd_rdy_q <= 1'b1;
      end else if (host.clr_cmd_rdy) begin
         cmd_rdy_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
      end else if ((frame_bad || to_err) && err_q != 8'hFF) begin
         err_q <= err_q + 8'd1;
      end
   end

   assign host.cmd     = cmd_q;
   assign host.data    = data_q;
   assign host.cmd_rdy = cmd_rdy_q;
   assign host.err_cnt = err_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - directed self-checking bench for uart_cmd_assembler
module tb_uart_cmd_assembler;
   import uart_cmd_pkg::*;

`ifdef CMD_TIMEOUT_EN
   localparam int TO_CYC = 100;
`else
   localparam int TO_CYC = 104160;
`endif

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   uart_byte_if rxb ();
   cmd_out_if   cmdb ();

   uart_cmd_assembler #(
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_CYC (TO_CYC),
      .TO_W        (17)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx    (rxb),
      .host  (cmdb)
   );

   always #5 clk = ~clk;

   // Receiver model: present a byte for one cycle; it is dropped after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      rxb.rx_data = b;
      rxb.rx_rdy  = 1'b1;
      @(negedge clk);
      rxb.rx_rdy  = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4);
      logic [7:0] fr [FRAME_LEN];
      fr = '{b0, b1, b2, b3, b4};
      for (int i = 0; i < FRAME_LEN; i++) send_byte(fr[i]);
   endtask

   task automatic pulse_clr;
      cmdb.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      cmdb.clr_cmd_rdy = 1'b0;
   endtask

   task automatic test_reset;
      total++; if (cmdb.cmd !== 8'h00)      $display("FAIL reset_cmd: got %h exp 00", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h0000)  $display("FAIL reset_data: got %h exp 0000", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b0)   $display("FAIL reset_cmd_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.err_cnt !== 8'h00)  $display("FAIL reset_err_cnt: got %h exp 00", cmdb.err_cnt); else passed++;
      total++; if (rxb.clr_rx_rdy !== 1'b0) $display("FAIL reset_clr_rx_rdy: got %b exp 0", rxb.clr_rx_rdy); else passed++;
   endtask

   task automatic test_good_frame;
      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
      rxb.rx_data = 8'h9C;
      rxb.rx_rdy  = 1'b1;
      #1;
      total++; if (rxb.clr_rx_rdy !== 1'b1) $display("FAIL good_clr_rx_rdy: got %b exp 1", rxb.clr_rx_rdy); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b0)   $display("FAIL good_rdy_early: got %b exp 0", cmdb.cmd_rdy); else passed++;
      @(negedge clk);
      rxb.rx_rdy = 1'b0;
      total++; if (cmdb.cmd !== 8'h12)      $display("FAIL good_cmd: got %h exp 12", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h3456)  $display("FAIL good_data: got %h exp 3456", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)   $display("FAIL good_cmd_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.err_cnt !== 8'h00)  $display("FAIL good_err: got %h exp 00", cmdb.err_cnt); else passed++;
   endtask

   task automatic test_bad_checksum;
      pulse_clr();
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL ack_clears: got %b exp 0", cmdb.cmd_rdy); else passed++;
      send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h00);
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL bad_cmd_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.cmd !== 8'h12)     $display("FAIL bad_cmd_kept: got %h exp 12", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h3456) $display("FAIL bad_data_kept: got %h exp 3456", cmdb.data); else passed++;
      total++; if (cmdb.err_cnt !== 8'h01) $display("FAIL bad_err: got %h exp 01", cmdb.err_cnt); else passed++;
   endtask

   task automatic test_leading_garbage;
      send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
      send_frame(8'hA5, 8'h01, 8'h00, 8'h02, 8'h03);
      total++; if (cmdb.cmd !== 8'h01)     $display("FAIL garbage_cmd: got %h exp 01", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h0002) $display("FAIL garbage_data: got %h exp 0002", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL garbage_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.err_cnt !== 8'h01) $display("FAIL garbage_err: got %h exp 01", cmdb.err_cnt); else passed++;
   endtask

   task automatic test_sync_payload;
      pulse_clr();
      send_frame(8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hEF);
      total++; if (cmdb.cmd !== 8'hA5)     $display("FAIL syncpay_cmd: got %h exp a5", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'hA5A5) $display("FAIL syncpay_data: got %h exp a5a5", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL syncpay_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
   endtask

   task automatic test_back_to_back;
      send_frame(8'hA5, 8'h01, 8'h00, 8'h02, 8'h03);
      send_frame(8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h7A);
      total++; if (cmdb.cmd !== 8'h02)     $display("FAIL b2b_cmd: got %h exp 02", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'hABCD) $display("FAIL b2b_data: got %h exp abcd", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL b2b_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
      pulse_clr();
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL b2b_ack: got %b exp 0", cmdb.cmd_rdy); else passed++;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
      rxb.rx_data      = 8'h03;
      rxb.rx_rdy       = 1'b1;
      cmdb.clr_cmd_rdy = 1'b1;
      @(negedge clk);
      rxb.rx_rdy       = 1'b0;
      cmdb.clr_cmd_rdy = 1'b0;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL set_wins_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.cmd !== 8'h01)     $display("FAIL set_wins_cmd: got %h exp 01", cmdb.cmd); else passed++;
      total++; if (cmdb.err_cnt !== 8'h01) $display("FAIL b2b_err: got %h exp 01", cmdb.err_cnt); else passed++;
   endtask

   task automatic test_saturation;
      #2 rst_n = 1'b0;
      #1;
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL async_rst_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.cmd !== 8'h00)     $display("FAIL async_rst_cmd: got %h exp 00", cmdb.cmd); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 255; i++) send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01);
      total++; if (cmdb.err_cnt !== 8'hFF) $display("FAIL sat_255: got %h exp ff", cmdb.err_cnt); else passed++;
      for (int i = 0; i < 5; i++) send_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h01);
      total++; if (cmdb.err_cnt !== 8'hFF) $display("FAIL sat_260: got %h exp ff", cmdb.err_cnt); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL sat_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
   endtask

   task automatic test_reset_mid_frame;
      send_frame(8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h7A);
      send_byte(8'hA5); send_byte(8'h12);
      #2 rst_n = 1'b0;
      #1;
      total++; if (cmdb.cmd !== 8'h00)     $display("FAIL midrst_cmd: got %h exp 00", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h0000) $display("FAIL midrst_data: got %h exp 0000", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL midrst_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.err_cnt !== 8'h00) $display("FAIL midrst_err: got %h exp 00", cmdb.err_cnt); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL partial_lost_rdy: got %b exp 0", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.err_cnt !== 8'h00) $display("FAIL partial_lost_err: got %h exp 00", cmdb.err_cnt); else passed++;
      send_frame(8'hA5, 8'h12, 8'h34, 8'h56, 8'h9C);
      total++; if (cmdb.cmd !== 8'h12)     $display("FAIL post_rst_cmd: got %h exp 12", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h3456) $display("FAIL post_rst_data: got %h exp 3456", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL post_rst_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
   endtask

`ifdef CMD_TIMEOUT_EN
   task automatic test_timeout;
      pulse_clr();
      send_byte(8'hA5); send_byte(8'h12);
      repeat (99) @(negedge clk);
      total++; if (cmdb.err_cnt !== 8'h00) $display("FAIL to_early: got %h exp 00", cmdb.err_cnt); else passed++;
      @(negedge clk);
      total++; if (cmdb.err_cnt !== 8'h01) $display("FAIL to_expire: got %h exp 01", cmdb.err_cnt); else passed++;
      send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      total++; if (cmdb.cmd_rdy !== 1'b0)  $display("FAIL to_dropped: got %b exp 0", cmdb.cmd_rdy); else passed++;
      send_frame(8'hA5, 8'h07, 8'h00, 8'h01, 8'h08);
      total++; if (cmdb.cmd !== 8'h07)     $display("FAIL to_next_cmd: got %h exp 07", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h0001) $display("FAIL to_next_data: got %h exp 0001", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL to_next_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
   endtask

   task automatic test_byte_on_expiry;
      pulse_clr();
      send_byte(8'hA5); send_byte(8'h12);
      repeat (99) @(negedge clk);
      send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      total++; if (cmdb.err_cnt !== 8'h01) $display("FAIL expiry_err: got %h exp 01", cmdb.err_cnt); else passed++;
      total++; if (cmdb.cmd !== 8'h12)     $display("FAIL expiry_cmd: got %h exp 12", cmdb.cmd); else passed++;
      total++; if (cmdb.data !== 16'h3456) $display("FAIL expiry_data: got %h exp 3456", cmdb.data); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL expiry_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
   endtask
`else
   task automatic test_no_timeout;
      pulse_clr();
      send_byte(8'hA5); send_byte(8'h12);
      repeat (200) @(negedge clk);
      send_byte(8'h34); send_byte(8'h56); send_byte(8'h9C);
      total++; if (cmdb.err_cnt !== 8'h00) $display("FAIL idle_err: got %h exp 00", cmdb.err_cnt); else passed++;
      total++; if (cmdb.cmd_rdy !== 1'b1)  $display("FAIL idle_rdy: got %b exp 1", cmdb.cmd_rdy); else passed++;
      total++; if (cmdb.data !== 16'h3456) $display("FAIL idle_data: got %h exp 3456", cmdb.data); else passed++;
   endtask
`endif

   initial begin
      clk              = 1'b0;
      rst_n            = 1'b0;
      passed           = 0;
      total            = 0;
      rxb.rx_data      = 8'h00;
      rxb.rx_rdy       = 1'b0;
      cmdb.clr_cmd_rdy = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_good_frame();
      test_bad_checksum();
      test_leading_garbage();
      test_sync_payload();
      test_back_to_back();
      test_saturation();
      test_reset_mid_frame();
`ifdef CMD_TIMEOUT_EN
      test_timeout();
      test_byte_on_expiry();
`else
      test_no_timeout();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
